// File: rtl/runner_ctrl_pkg.sv
// Shared types and constants for the runner game-state controller.
// The optional pause feature is selected with RUNNER_CTRL_PAUSE_EN.
package runner_ctrl_pkg;

    typedef enum logic [1:0] {
        WAITING = 2'd0,
        RUNNING = 2'd1,
        CRASHED = 2'd2,
        PAUSED  = 2'd3
    } state_t;

    // Bounding box: x is signed so obstacles can slide off the left edge.
    typedef struct packed {
        logic signed [10:0] x;
        logic        [9:0]  y;
        logic        [9:0]  w;
        logic        [9:0]  h;
    } box_t;

    localparam int SPEED_SCALE = 1024;

    function automatic logic signed [11:0] sext12(input logic signed [10:0] v);
        return {v[10], v};
    endfunction

    function automatic logic signed [11:0] zext12(input logic [9:0] v);
        return {2'b00, v};
    endfunction

endpackage

// File: rtl/runner_ctrl_if.sv
// Control/status bundle between the strobe logic and runner_ctrl.
// The pause member exists only when RUNNER_CTRL_PAUSE_EN is defined.
interface runner_ctrl_if
    import runner_ctrl_pkg::*;
#(
    parameter int N_OBS   = 3,
    parameter int SPEED_W = 15
);
    localparam int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;

    logic               update;
    logic               jump;
    logic               duck;
`ifdef RUNNER_CTRL_PAUSE_EN
    logic               pause;
`endif
    box_t               trex_box;
    logic [N_OBS-1:0]   obs_valid;
    box_t [N_OBS-1:0]   obs_box;
    state_t             state;
    logic [5:0]         timer;
    logic [SPEED_W-1:0] speed;
    logic               has_obstacles;
    logic               duck_out;
    logic               scan_busy;
    logic               crash;
    logic [IDX_W-1:0]   hit_idx;
    logic               restart;

    modport master (
`ifdef RUNNER_CTRL_PAUSE_EN
        output pause,
`endif
        output update, jump, duck, trex_box, obs_valid, obs_box,
        input  state, timer, speed, has_obstacles, duck_out, scan_busy,
               crash, hit_idx, restart
    );

    modport slave (
`ifdef RUNNER_CTRL_PAUSE_EN
        input  pause,
`endif
        input  update, jump, duck, trex_box, obs_valid, obs_box,
        output state, timer, speed, has_obstacles, duck_out, scan_busy,
               crash, hit_idx, restart
    );

endinterface

// File: rtl/runner_ctrl_box_overlap.sv
// Combinational strict-overlap test between two boxes at 12-bit signed
// precision; empty boxes never overlap and touching edges do not count.
module box_overlap
    import runner_ctrl_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic hit
);
    logic signed [11:0] ax_s, ay_s, aw_s, ah_s;
    logic signed [11:0] bx_s, by_s, bw_s, bh_s;
    logic               empty_s;

    // Extend fields and evaluate the four strict edge comparisons.
    always_comb begin
        ax_s    = sext12(a.x);
        bx_s    = sext12(b.x);
        ay_s    = zext12(a.y);
        by_s    = zext12(b.y);
        aw_s    = zext12(a.w);
        bw_s    = zext12(b.w);
        ah_s    = zext12(a.h);
        bh_s    = zext12(b.h);
        empty_s = (a.w == 10'd0) || (a.h == 10'd0) || (b.w == 10'd0) || (b.h == 10'd0);
        hit     = !empty_s && (ax_s < bx_s + bw_s) && (bx_s < ax_s + aw_s) &&
                  (ay_s < by_s + bh_s) && (by_s < ay_s + ah_s);
    end

endmodule

// File: rtl/runner_ctrl.sv
// Runner game-state controller: FSM, frame timer, speed ramp, obstacle gating,
// timed restart and a one-slot-per-cycle collision scan. Pause: RUNNER_CTRL_PAUSE_EN.
module runner_ctrl
    import runner_ctrl_pkg::*;
#(
    parameter int FPS           = 60,
    parameter int CLEAR_TIME    = 180,
    parameter int SPEED_INIT    = 6144,
    parameter int MAX_SPEED     = 13312,
    parameter int ACCEL         = 1,
    parameter int SPEED_W       = 15,
    parameter int N_OBS         = 3,
    parameter int RESTART_DELAY = 45
) (
    input logic         clk,
    input logic         rst,
    runner_ctrl_if.slave bus
);
    localparam int                 IDX_W        = (N_OBS > 1) ? $clog2(N_OBS) : 1;
    localparam int                 RT_W         = $clog2(RESTART_DELAY + 1);
    localparam logic [5:0]         TIMER_LAST   = 6'(FPS - 1);
    localparam logic [SPEED_W-1:0] SPEED_INIT_C = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W-1:0] SPEED_MAX_C  = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] SPEED_KNEE_C = SPEED_W'(MAX_SPEED - ACCEL);
    localparam logic [SPEED_W-1:0] ACCEL_C      = SPEED_W'(ACCEL);
    localparam logic [7:0]         CLEAR_C      = 8'((CLEAR_TIME > 255) ? 255 : CLEAR_TIME);
    localparam logic [RT_W-1:0]    RT_LAST      = RT_W'(RESTART_DELAY);
    localparam logic [RT_W-1:0]    RT_ONE       = RT_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(N_OBS - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE      = IDX_W'(1);

    state_t             state_r, state_nxt_s;
    logic [5:0]         timer_r, timer_nxt_s;
    logic [SPEED_W-1:0] speed_r, speed_nxt_s;
    logic [7:0]         clear_r, clear_nxt_s;
    logic [RT_W-1:0]    rt_r, rt_nxt_s;
    logic               has_obs_r, has_obs_nxt_s;
    logic               accel_en_r, accel_en_nxt_s;
    logic               scan_busy_r, scan_busy_nxt_s;
    logic [IDX_W-1:0]   scan_idx_r, scan_idx_nxt_s;
    logic [IDX_W-1:0]   hit_idx_r, hit_idx_nxt_s;
    logic               crash_r, crash_nxt_s;
    logic               restart_r, restart_nxt_s;
    logic               go_run_s, pause_s, overlap_s, slot_hit_s;
    box_t               probe_s;

`ifdef RUNNER_CTRL_PAUSE_EN
    assign pause_s = bus.pause;
`else
    assign pause_s = 1'b0;
`endif

    // One comparator, fed by whichever slot the scan is visiting this cycle.
    always_comb begin
        probe_s    = bus.obs_box[scan_idx_r];
        slot_hit_s = scan_busy_r && bus.obs_valid[scan_idx_r] && has_obs_r && overlap_s;
    end

    box_overlap u_overlap (
        .a   (bus.trex_box),
        .b   (probe_s),
        .hit (overlap_s)
    );

    // Next-state decode for the game FSM, frame counters and collision scan.
    always_comb begin
        state_nxt_s     = state_r;
        timer_nxt_s     = timer_r;
        speed_nxt_s     = speed_r;
        clear_nxt_s     = clear_r;
        rt_nxt_s        = rt_r;
        has_obs_nxt_s   = has_obs_r;
        accel_en_nxt_s  = accel_en_r;
        scan_busy_nxt_s = scan_busy_r;
        scan_idx_nxt_s  = scan_idx_r;
        hit_idx_nxt_s   = hit_idx_r;
        crash_nxt_s     = 1'b0;
        restart_nxt_s   = 1'b0;
        go_run_s        = 1'b0;
        case (state_r)
            WAITING: begin
                if (bus.update && bus.jump) begin
                    state_nxt_s = RUNNING;
                    go_run_s    = 1'b1;
                end else begin
                    go_run_s    = 1'b0;
                end
            end
            RUNNING: begin
                if (bus.update && pause_s) begin
                    state_nxt_s     = PAUSED;
                    scan_busy_nxt_s = 1'b0;
                end else if (bus.update) begin
                    // A new frame always wins over an unfinished scan.
                    timer_nxt_s     = (timer_r == TIMER_LAST) ? 6'd0 : timer_r + 6'd1;
                    speed_nxt_s     = !accel_en_r ? speed_r :
                                      (speed_r >= SPEED_KNEE_C) ? SPEED_MAX_C : speed_r + ACCEL_C;
                    accel_en_nxt_s  = 1'b1;
                    clear_nxt_s     = (clear_r == 8'hFF) ? clear_r : clear_r + 8'd1;
                    has_obs_nxt_s   = has_obs_r || (clear_r > CLEAR_C);
                    scan_busy_nxt_s = 1'b1;
                    scan_idx_nxt_s  = '0;
                end else if (slot_hit_s) begin
                    state_nxt_s     = CRASHED;
                    crash_nxt_s     = 1'b1;
                    hit_idx_nxt_s   = scan_idx_r;
                    scan_busy_nxt_s = 1'b0;
                    rt_nxt_s        = '0;
                end else if (scan_busy_r && (scan_idx_r != IDX_LAST)) begin
                    scan_idx_nxt_s  = scan_idx_r + IDX_ONE;
                end else begin
                    scan_busy_nxt_s = 1'b0;
                end
            end
            CRASHED: begin
                if (bus.update && bus.jump && (rt_r == RT_LAST)) begin
                    state_nxt_s   = RUNNING;
                    go_run_s      = 1'b1;
                    restart_nxt_s = 1'b1;
                end else if (bus.update && (rt_r != RT_LAST)) begin
                    rt_nxt_s      = rt_r + RT_ONE;
                end else begin
                    rt_nxt_s      = rt_r;
                end
            end
`ifdef RUNNER_CTRL_PAUSE_EN
            PAUSED: begin
                if (bus.update && bus.jump && !pause_s) begin
                    state_nxt_s = RUNNING;
                end else begin
                    state_nxt_s = PAUSED;
                end
            end
`endif
            default: state_nxt_s = WAITING;
        endcase
        if (go_run_s) begin
            timer_nxt_s     = 6'd0;
            speed_nxt_s     = SPEED_INIT_C;
            clear_nxt_s     = 8'd0;
            rt_nxt_s        = '0;
            has_obs_nxt_s   = 1'b0;
            accel_en_nxt_s  = 1'b0;
            scan_busy_nxt_s = 1'b0;
            scan_idx_nxt_s  = '0;
        end else begin
            go_run_s        = 1'b0;
        end
    end

    // State and counter registers; reset drops any pending pulse at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= WAITING;
            timer_r     <= 6'd0;
            speed_r     <= '0;
            clear_r     <= 8'd0;
            rt_r        <= '0;
            has_obs_r   <= 1'b0;
            accel_en_r  <= 1'b0;
            scan_busy_r <= 1'b0;
            scan_idx_r  <= '0;
            hit_idx_r   <= '0;
            crash_r     <= 1'b0;
            restart_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            speed_r     <= speed_nxt_s;
            clear_r     <= clear_nxt_s;
            rt_r        <= rt_nxt_s;
            has_obs_r   <= has_obs_nxt_s;
            accel_en_r  <= accel_en_nxt_s;
            scan_busy_r <= scan_busy_nxt_s;
            scan_idx_r  <= scan_idx_nxt_s;
            hit_idx_r   <= hit_idx_nxt_s;
            crash_r     <= crash_nxt_s;
            restart_r   <= restart_nxt_s;
        end
    end

    assign bus.state         = state_r;
    assign bus.timer         = timer_r;
    assign bus.speed         = speed_r;
    assign bus.has_obstacles = has_obs_r;
    assign bus.scan_busy     = scan_busy_r;
    assign bus.crash         = crash_r;
    assign bus.hit_idx       = hit_idx_r;
    assign bus.restart       = restart_r;
    assign bus.duck_out      = bus.duck && (state_r == RUNNING);

endmodule

// File: tb/tb_runner_ctrl.sv
// Randomised self-checking bench for runner_ctrl against a frame-level model.
// Pause scenarios are included when RUNNER_CTRL_PAUSE_EN is defined.
module tb_runner_ctrl;
    import runner_ctrl_pkg::*;

    localparam int FPS = 60, CLEAR_TIME = 180, SPEED_INIT = 6144, MAX_SPEED = 13312;
    localparam int ACCEL = 1, N_OBS = 3, RESTART_DELAY = 45;
    localparam int ST_WAIT = 0, ST_RUN = 1, ST_CRASH = 2, ST_PAUSE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    runner_ctrl_if #(.N_OBS(N_OBS), .SPEED_W(15)) bus ();

    runner_ctrl #(
        .FPS(FPS), .CLEAR_TIME(CLEAR_TIME), .SPEED_INIT(SPEED_INIT), .MAX_SPEED(MAX_SPEED),
        .ACCEL(ACCEL), .SPEED_W(15), .N_OBS(N_OBS), .RESTART_DELAY(RESTART_DELAY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level model: frames since (re)start, crash-side update count.
    int m_state = ST_WAIT;
    int m_k = 0;
    int m_rt = 0;
    bit m_live = 1'b0;
    int tx = 100, ty = 60, tw = 20, th = 22;
    int ox[N_OBS], oy[N_OBS], ow[N_OBS], oh[N_OBS];
    bit ov[N_OBS];
    bit duck_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_speed();
        int s;
        if (!m_live) return 0;
        s = SPEED_INIT + ACCEL * ((m_k > 0) ? m_k - 1 : 0);
        return (s > MAX_SPEED) ? MAX_SPEED : s;
    endfunction

    function automatic bit exp_has();
        return m_live && (m_k > CLEAR_TIME + 1);
    endfunction

    function automatic bit ovl(input int ax, ay, aw, ah, bx, by, bw, bh);
        if (aw == 0 || ah == 0 || bw == 0 || bh == 0) return 1'b0;
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    function automatic int first_hit();
        for (int i = 0; i < N_OBS; i++)
            if (ov[i] && exp_has() && ovl(tx, ty, tw, th, ox[i], oy[i], ow[i], oh[i])) return i;
        return -1;
    endfunction

    task automatic apply_inputs();
        bus.trex_box.x = 11'(tx);
        bus.trex_box.y = 10'(ty);
        bus.trex_box.w = 10'(tw);
        bus.trex_box.h = 10'(th);
        for (int i = 0; i < N_OBS; i++) begin
            bus.obs_box[i].x = 11'(ox[i]);
            bus.obs_box[i].y = 10'(oy[i]);
            bus.obs_box[i].w = 10'(ow[i]);
            bus.obs_box[i].h = 10'(oh[i]);
            bus.obs_valid[i] = ov[i];
        end
        bus.duck = duck_v;
    endtask

    task automatic rand_boxes(input bit allow_valid);
        tx = 100; ty = 60; tw = 20; th = 22;
        for (int i = 0; i < N_OBS; i++) begin
            ox[i] = tx - 40 + int'($urandom_range(80));
            oy[i] = ty - 30 + int'($urandom_range(60));
            ow[i] = int'($urandom_range(25));
            oh[i] = int'($urandom_range(25));
            ov[i] = allow_valid ? 1'($urandom_range(1)) : 1'b0;
        end
        duck_v = 1'($urandom_range(1));
    endtask

    task automatic check_outputs();
        check("state", bus.state, m_state);
        check("timer", bus.timer, m_k % FPS);
        check("speed", bus.speed, exp_speed());
        check("has_obstacles", bus.has_obstacles, exp_has());
        check("duck_out", bus.duck_out, duck_v && (m_state == ST_RUN));
    endtask

    // One frame: update strobe, then watch the scan and any crash pulse.
    task automatic frame(input bit jmp, input bit pz);
        bit scan, rpulse, crashed;
        int hit;
        apply_inputs();
        bus.update = 1'b1;
        bus.jump   = jmp;
`ifdef RUNNER_CTRL_PAUSE_EN
        bus.pause  = pz;
`endif
        @(posedge clk); #1;
        bus.update = 1'b0;
        bus.jump   = 1'b0;
        scan = 1'b0; rpulse = 1'b0; crashed = 1'b0;
        case (m_state)
            ST_WAIT:  if (jmp) begin m_state = ST_RUN; m_k = 0; m_live = 1'b1; end
            ST_RUN:   if (pz) m_state = ST_PAUSE; else begin m_k++; scan = 1'b1; end
            ST_CRASH: if (jmp && m_rt == RESTART_DELAY) begin
                          m_state = ST_RUN; m_k = 0; rpulse = 1'b1;
                      end else if (m_rt < RESTART_DELAY) m_rt++;
            ST_PAUSE: if (jmp && !pz) m_state = ST_RUN;
            default:  m_state = ST_WAIT;
        endcase
        check_outputs();
        check("restart", bus.restart, rpulse);
        check("crash_at_update", bus.crash, 0);
        check("scan_start", bus.scan_busy, scan);
        if (scan) begin
            hit = first_hit();
            for (int c = 1; c <= N_OBS && !crashed; c++) begin
                @(posedge clk); #1;
                if (hit == c - 1) begin
                    check("crash", bus.crash, 1);
                    check("hit_idx", bus.hit_idx, hit);
                    check("scan_abort", bus.scan_busy, 0);
                    m_state = ST_CRASH; m_rt = 0; crashed = 1'b1;
                    check("crash_state", bus.state, m_state);
                end else begin
                    check("no_crash", bus.crash, 0);
                    check("scan_busy", bus.scan_busy, c < N_OBS);
                    check("run_state", bus.state, m_state);
                end
            end
        end
        @(posedge clk); #1;
        check("crash_pulse_end", bus.crash, 0);
        check("restart_pulse_end", bus.restart, 0);
        check_outputs();
    endtask

    task automatic recover();
        for (int u = 1; u <= RESTART_DELAY + 1; u++)
            frame((u == RESTART_DELAY - 1) || (u == RESTART_DELAY + 1), 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.update = 1'b0; bus.jump = 1'b0;
`ifdef RUNNER_CTRL_PAUSE_EN
        bus.pause = 1'b0;
`endif
        rand_boxes(1'b0);
        apply_inputs();
        #12;
        check("rst_state", bus.state, ST_WAIT);
        check("rst_timer", bus.timer, 0);
        check("rst_speed", bus.speed, 0);
        check("rst_has", bus.has_obstacles, 0);
        check("rst_scan", bus.scan_busy, 0);
        check("rst_crash", bus.crash, 0);
        check("rst_restart", bus.restart, 0);
        check("rst_hit_idx", bus.hit_idx, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        // Ramp to the clamp; early frames carry random obstacles that must be gated off.
        for (int f = 1; f <= 7200; f++) begin
            rand_boxes(f <= CLEAR_TIME + 1);
            frame(1'($urandom_range(1)), 1'b0);
        end
        check("speed_clamped", bus.speed, MAX_SPEED);

        tx = 4; ty = 50; tw = 20; th = 20;
        ox[0] = -21; oy[0] = 50; ow[0] = 25; oh[0] = 10; ov[0] = 1'b1;
        ov[1] = 1'b0; ov[2] = 1'b0;
        frame(1'b0, 1'b0);
        check("neg_x_miss", bus.state, ST_RUN);

        ox[0] = tx + tw; oy[0] = ty; ow[0] = 10; oh[0] = 10; ov[0] = 1'b1;
        ox[1] = 10;      oy[1] = ty; ow[1] = 10; oh[1] = 10; ov[1] = 1'b0;
        ox[2] = tx + tw - 1; oy[2] = ty; ow[2] = 10; oh[2] = 10; ov[2] = 1'b1;
        frame(1'b0, 1'b0);
        check("hit2_state", bus.state, ST_CRASH);
        recover();
        check("restart_speed", bus.speed, SPEED_INIT);
        check("restart_has", bus.has_obstacles, 0);

        for (int i = 0; i < N_OBS; i++) ov[i] = 1'b0;
        for (int f = 0; f < CLEAR_TIME + 2; f++) frame(1'b0, 1'b0);
        ox[0] = -20; oy[0] = 50; ow[0] = 25; oh[0] = 10; ov[0] = 1'b1;
        frame(1'b0, 1'b0);
        check("neg_x_hit", bus.hit_idx, 0);
        recover();

        for (int f = 0; f < 600; f++) begin
            rand_boxes(1'b1);
            frame($urandom_range(3) == 0, 1'b0);
        end

        for (int i = 0; i < N_OBS; i++) ov[i] = 1'b0;
        for (int f = 0; f < RESTART_DELAY + 2 && m_state != ST_RUN; f++) frame(1'b1, 1'b0);
        check("pre_reset_run", bus.state, ST_RUN);
        apply_inputs();
        bus.update = 1'b1;
        @(posedge clk); #1;
        bus.update = 1'b0;
        check("midscan_busy", bus.scan_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("midscan_rst_busy", bus.scan_busy, 0);
        check("midscan_rst_state", bus.state, ST_WAIT);
        check("midscan_rst_speed", bus.speed, 0);
        check("midscan_rst_crash", bus.crash, 0);
        m_state = ST_WAIT; m_k = 0; m_rt = 0; m_live = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_outputs();

`ifdef RUNNER_CTRL_PAUSE_EN
        frame(1'b1, 1'b0);
        for (int f = 0; f < 5; f++) frame(1'b0, 1'b0);
        frame(1'b0, 1'b1);
        check("paused", bus.state, ST_PAUSE);
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        check("resumed", bus.state, ST_RUN);
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
